// File: rtl/resp_framer_if.sv
// resp_framer_if: request, payload and tx byte-stream handshakes of the response framer.
interface resp_framer_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [7:0]           req_opcode;
    logic [7:0]           req_status;
    logic [LEN_WIDTH-1:0] req_len;
    logic [7:0]           pl_data;
    logic                 pl_valid;
    logic                 pl_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output req_valid, req_opcode, req_status, req_len, pl_data, pl_valid, tx_ready,
        input  req_ready, pl_ready, tx_data, tx_valid
    );
    modport slave (
        input  req_valid, req_opcode, req_status, req_len, pl_data, pl_valid, tx_ready,
        output req_ready, pl_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/resp_framer.sv
// resp_framer: streams SOF, header, payload and checksum bytes of a response frame to the tx FIFO.
// Optional payload starvation timeout is enabled by defining RESP_FRAMER_TIMEOUT_EN.
module resp_framer #(
    parameter int         LEN_WIDTH      = 16,
    parameter int         MAX_LEN        = 512,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    resp_framer_if.slave bus,
    output logic         busy_o,
    output logic         frame_done_o,
    output logic         len_err_o,
    output logic         timeout_err_o
);
    typedef enum logic [2:0] {IDLE, SOF, OPC, STAT, LENH, LENL, PAYLOAD, CHK} state_e;

    state_e               state_q, state_d;
    logic [7:0]           tx_data_q, tx_data_d, opc_q, opc_d, stat_q, stat_d, sum_q, sum_d, pl_byte;
    logic [LEN_WIDTH-1:0] len_q, len_d, rem_q, rem_d;
    logic                 tx_valid_q, tx_valid_d, chk_ld_q, chk_ld_d, len_err_q, len_err_d;
    logic                 can_load, pl_take, fill;

    assign can_load = !tx_valid_q || bus.tx_ready;
    assign pl_take  = state_q == PAYLOAD && can_load && (fill || bus.pl_valid);
    assign pl_byte  = fill ? 8'h00 : bus.pl_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            opc_q      <= '0;
            stat_q     <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            sum_q      <= '0;
            chk_ld_q   <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            opc_q      <= opc_d;
            stat_q     <= stat_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            sum_q      <= sum_d;
            chk_ld_q   <= chk_ld_d;
            len_err_q  <= len_err_d;
        end
    end

    // Output register drains by default; each state reloads it only when it can accept a byte.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !bus.tx_ready;
        opc_d      = opc_q;
        stat_d     = stat_q;
        len_d      = len_q;
        rem_d      = rem_q;
        sum_d      = sum_q;
        chk_ld_d   = chk_ld_q;
        len_err_d  = 1'b0;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                opc_d     = bus.req_opcode;
                stat_d    = bus.req_status;
                len_d     = bus.req_len;
                sum_d     = '0;
                len_err_d = bus.req_len > LEN_WIDTH'(MAX_LEN);
                state_d   = len_err_d ? IDLE : SOF;
            end
            SOF: if (can_load) begin
                tx_data_d  = SOF_BYTE;
                tx_valid_d = 1'b1;
                state_d    = OPC;
            end
            OPC: if (can_load) begin
                tx_data_d  = opc_q;
                tx_valid_d = 1'b1;
                sum_d      = sum_q + opc_q;
                state_d    = STAT;
            end
            STAT: if (can_load) begin
                tx_data_d  = stat_q;
                tx_valid_d = 1'b1;
                sum_d      = sum_q + stat_q;
                state_d    = LENH;
            end
            LENH: if (can_load) begin
                tx_data_d  = len_q[15:8];
                tx_valid_d = 1'b1;
                sum_d      = sum_q + len_q[15:8];
                state_d    = LENL;
            end
            LENL: if (can_load) begin
                tx_data_d  = len_q[7:0];
                tx_valid_d = 1'b1;
                sum_d      = sum_q + len_q[7:0];
                rem_d      = len_q;
                state_d    = len_q != '0 ? PAYLOAD : CHK;
            end
            PAYLOAD: if (pl_take) begin
                tx_data_d  = pl_byte;
                tx_valid_d = 1'b1;
                sum_d      = sum_q + pl_byte;
                rem_d      = rem_q - LEN_WIDTH'(1);
                state_d    = rem_q == LEN_WIDTH'(1) ? CHK : PAYLOAD;
            end
            CHK: if (!chk_ld_q && can_load) begin
                tx_data_d  = -sum_q;
                tx_valid_d = 1'b1;
                chk_ld_d   = 1'b1;
            end else if (chk_ld_q && bus.tx_ready) begin
                chk_ld_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = state_q == IDLE;
        bus.pl_ready  = state_q == PAYLOAD && can_load && !fill;
        bus.tx_data   = tx_data_q;
        bus.tx_valid  = tx_valid_q;
        busy_o        = state_q != IDLE;
        frame_done_o  = state_q == CHK && chk_ld_q && bus.tx_ready;
        len_err_o     = len_err_q;
    end

`ifdef RESP_FRAMER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          fill_q, fill_d, to_err_q, to_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            fill_q   <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            fill_q   <= fill_d;
            to_err_q <= to_err_d;
        end
    end

    // Once starved, the rest of the payload is zero-filled without further handshakes.
    always_comb begin
        to_cnt_d = to_cnt_q;
        fill_d   = fill_q;
        to_err_d = 1'b0;
        if (state_q != PAYLOAD) begin
            to_cnt_d = '0;
            fill_d   = 1'b0;
        end else if (pl_take) begin
            to_cnt_d = '0;
        end else if (can_load) begin
            to_cnt_d = to_cnt_q + TW'(1);
            fill_d   = to_cnt_q == TW'(TIMEOUT_CYCLES - 1);
            to_err_d = fill_d;
        end
    end

    assign fill          = fill_q;
    assign timeout_err_o = to_err_q;
`else
    assign fill          = 1'b0;
    assign timeout_err_o = 1'b0;
`endif
endmodule
